// File: rtl/seq_det_pkg.sv
// Shared constants, active-configuration struct and length validity helper
// for the parametrised serial pattern detector.
package seq_det_pkg;

   localparam int                  SD_MAX_LEN     = 8;
   localparam logic [SD_MAX_LEN-1:0] SD_DEF_PATTERN = 8'b0001_0010;
   localparam int                  SD_DEF_LEN     = 5;
   localparam logic                SD_DEF_OVERLAP = 1'b1;

   // Storage caps for the config struct; instances may use MAX_LEN 2..31.
   localparam int SD_PAT_CAP   = 32;
   localparam int SD_LEN_CAP_W = 6;

   typedef struct packed {
      logic [SD_PAT_CAP-1:0]   pat;
      logic [SD_LEN_CAP_W-1:0] len;
      logic                    ovl;
   } cfg_t;

   // A length outside 1..max_len can never produce a hit.
   function automatic logic len_ok(input logic [SD_LEN_CAP_W-1:0] len, input int max_len);
      return (len != '0) && (int'(len) <= max_len);
   endfunction

endpackage

// File: rtl/seq_det_if.sv
// Config + serial-stream bundle of the pattern detector.
// match_cnt/cnt_clr are present only when SEQ_DET_CNT_EN is defined.
interface seq_det_if #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = $clog2(MAX_LEN+1)
`ifdef SEQ_DET_CNT_EN
   , parameter int CNT_W = 16
`endif
) ();

   logic               cfg_we;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic               in_valid;
   logic               data_in;
   logic               match;
`ifdef SEQ_DET_CNT_EN
   logic               cnt_clr;
   logic [CNT_W-1:0]   match_cnt;
`endif

   modport master (
      output cfg_we, cfg_pattern, cfg_len, cfg_overlap, in_valid, data_in,
      input  match
`ifdef SEQ_DET_CNT_EN
      , output cnt_clr
      , input  match_cnt
`endif
   );

   modport slave (
      input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, in_valid, data_in,
      output match
`ifdef SEQ_DET_CNT_EN
      , input  cnt_clr
      , output match_cnt
`endif
   );

endinterface

// File: rtl/seq_det_cmp.sv
// Masked compare of the post-shift history against the low len pattern bits.
module seq_det_cmp #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = $clog2(MAX_LEN+1)
) (
   input  logic [MAX_LEN-1:0] hist_n_i,
   input  logic [MAX_LEN-1:0] pat_i,
   input  logic [LEN_W-1:0]   len_i,
   input  logic               len_vld_i,
   input  logic [LEN_W-1:0]   fill_n_i,
   output logic               hit_o
);

   logic [MAX_LEN-1:0] mask;

   always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++)
         mask[i] = (LEN_W'(i) < len_i);
   end

   assign hit_o = len_vld_i && (fill_n_i >= len_i) && (((hist_n_i ^ pat_i) & mask) == '0);

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-configurable serial bit-pattern detector with registered match pulse.
// Optional saturating match counter built only when SEQ_DET_CNT_EN is defined.
module seq_detect_param
   import seq_det_pkg::*;
#(
   parameter int               MAX_LEN     = SD_MAX_LEN,
   parameter int               LEN_W       = $clog2(MAX_LEN+1),
   parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(SD_DEF_PATTERN),
   parameter logic [LEN_W-1:0] DEF_LEN     = LEN_W'(SD_DEF_LEN),
   parameter logic             DEF_OVERLAP = SD_DEF_OVERLAP
`ifdef SEQ_DET_CNT_EN
   , parameter int             CNT_W       = 16
`endif
) (
   input logic      clk,
   input logic      rst_n,
   seq_det_if.slave bus
);

   localparam cfg_t CFG_RST = '{pat: SD_PAT_CAP'(DEF_PATTERN),
                                len: SD_LEN_CAP_W'(DEF_LEN),
                                ovl: DEF_OVERLAP};

   logic [MAX_LEN-1:0] hist_q, hist_d, hist_n;
   logic [LEN_W-1:0]   fill_q, fill_d, fill_n;
   cfg_t               cfg_q, cfg_d;
   logic               match_q, match_d;
   logic               accept, len_vld, hit;
   logic               cfg_unused;

   // A config write wins over a bit presented in the same cycle.
   assign accept     = bus.in_valid & ~bus.cfg_we;
   assign hist_n     = {hist_q[MAX_LEN-2:0], bus.data_in};
   assign fill_n     = (fill_q >= LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
   assign len_vld    = len_ok(cfg_q.len, MAX_LEN);
   assign cfg_unused = ^cfg_q.pat[SD_PAT_CAP-1:MAX_LEN];

   seq_det_cmp #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_cmp (
      .hist_n_i  (hist_n),
      .pat_i     (cfg_q.pat[MAX_LEN-1:0]),
      .len_i     (cfg_q.len[LEN_W-1:0]),
      .len_vld_i (len_vld),
      .fill_n_i  (fill_n),
      .hit_o     (hit)
   );

   always_comb begin
      hist_d  = hist_q;
      fill_d  = fill_q;
      cfg_d   = cfg_q;
      match_d = 1'b0;
      if (bus.cfg_we) begin
         cfg_d.pat = SD_PAT_CAP'(bus.cfg_pattern);
         cfg_d.len = SD_LEN_CAP_W'(bus.cfg_len);
         cfg_d.ovl = bus.cfg_overlap;
         fill_d    = '0;
      end else if (accept) begin
         hist_d  = hist_n;
         match_d = hit;
         // Non-overlapping mode forgets the history consumed by this match.
         fill_d  = (hit && !cfg_q.ovl) ? '0 : fill_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q  <= '0;
         fill_q  <= '0;
         cfg_q   <= CFG_RST;
         match_q <= 1'b0;
      end else begin
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         cfg_q   <= cfg_d;
         match_q <= match_d;
      end
   end

   assign bus.match = match_q;

`ifdef SEQ_DET_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Clear and hit together leave a count of one.
   always_comb begin
      cnt_d = cnt_q;
      if (bus.cnt_clr)
         cnt_d = CNT_W'(accept & hit);
      else if (accept && hit && (cnt_q != '1))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign bus.match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: a queue-of-bits reference model feeds
// expected match/count values to an independent per-cycle monitor.
module tb_seq_detect_param;
   import seq_det_pkg::*;

   localparam int ML   = 8;
   localparam int LW   = $clog2(ML+1);
   localparam int CW   = 3;
   localparam int CMAX = (1 << CW) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

`ifdef SEQ_DET_CNT_EN
   seq_det_if #(.MAX_LEN(ML), .CNT_W(CW)) bus ();
   seq_detect_param #(.MAX_LEN(ML), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
   seq_det_if #(.MAX_LEN(ML)) bus ();
   seq_detect_param #(.MAX_LEN(ML)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

   typedef struct { bit m; int c; } exp_t;
   exp_t sb[$];
   int total = 0, bad = 0, obs = 0, last_cnt = 0;

   // Reference model: the accepted bits still usable for a match, newest last.
   bit [ML-1:0] m_pat;
   int          m_len;
   bit          m_ovl;
   bit          win[$];
   int          m_cnt;

   task automatic model_reset();
      m_pat = SD_DEF_PATTERN; m_len = SD_DEF_LEN; m_ovl = SD_DEF_OVERLAP;
      win.delete(); m_cnt = 0;
   endtask

   task automatic push_exp(input bit m, input int c);
      exp_t e;
      e.m = m; e.c = c;
      sb.push_back(e);
   endtask

   task automatic cyc(input bit we, input logic [ML-1:0] p, input int l, input bit o,
                      input bit v, input bit d, input bit clr);
      bit hit;
      @(negedge clk);
      bus.cfg_we = we; bus.cfg_pattern = p; bus.cfg_len = LW'(l); bus.cfg_overlap = o;
      bus.in_valid = v; bus.data_in = d;
`ifdef SEQ_DET_CNT_EN
      bus.cnt_clr = clr;
`endif
      hit = 1'b0;
      if (we) begin
         m_pat = p; m_len = l & ((1 << LW) - 1); m_ovl = o; win.delete();
      end else if (v) begin
         win.push_back(d);
         if (win.size() > ML) void'(win.pop_front());
         if (m_len >= 1 && m_len <= ML && win.size() >= m_len) begin
            hit = 1'b1;
            for (int k = 0; k < m_len; k++)
               if (win[win.size()-1-k] != m_pat[k]) hit = 1'b0;
         end
         if (hit && !m_ovl) win.delete();
      end
      if (clr) m_cnt = hit ? 1 : 0;
      else if (hit && m_cnt < CMAX) m_cnt++;
      push_exp(hit, m_cnt);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, '0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic cfg(input logic [ML-1:0] p, input int l, input bit o);
      cyc(1'b1, p, l, o, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic send(input logic [31:0] b, input int n);
      logic [31:0] bv;
      bv = b;
      for (int i = n - 1; i >= 0; i--) cyc(1'b0, '0, 0, 1'b0, 1'b1, bv[i], 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.cfg_we = 1'b0; bus.in_valid = 1'b0; bus.data_in = 1'b0;
`ifdef SEQ_DET_CNT_EN
      bus.cnt_clr = 1'b0;
`endif
      model_reset();
      push_exp(1'b0, 0);
      @(negedge clk);
      push_exp(1'b0, 0);
      rst_n = 1'b1;
   endtask

   task automatic chk(input string n, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", n, act, want);
      end
   endtask

   // Let the monitor consume every queued expectation before a tally check.
   task automatic drain();
      idle(2);
      for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
      #2;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d want=0 pending", sb.size());
      end
   endtask

   // Monitor: the detector presents match every cycle.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (bus.match === 1'b1) obs++;
         total++;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            if (bus.match !== e.m) begin
               bad++;
               $display("FAIL match t=%0t got=%b want=%b", $time, bus.match, e.m);
            end
`ifdef SEQ_DET_CNT_EN
            total++;
            if (bus.match_cnt !== CW'(e.c)) begin
               bad++;
               $display("FAIL match_cnt t=%0t got=%0d want=%0d", $time, bus.match_cnt, e.c);
            end
            last_cnt = int'(bus.match_cnt);
`endif
         end else if (bus.match !== 1'b0) begin
            bad++;
            $display("FAIL idle_match t=%0t got=%b want=0", $time, bus.match);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

   initial begin
      int o0;
      bus.cfg_we = 1'b0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 1'b0;
      bus.in_valid = 1'b0; bus.data_in = 1'b0;
`ifdef SEQ_DET_CNT_EN
      bus.cnt_clr = 1'b0;
`endif
      model_reset();
      do_reset();

      // Default 10010 overlapping
      o0 = obs; send(32'b10010010, 8); drain();
      chk("dflt_ovl_matches", obs - o0, 2);
`ifdef SEQ_DET_CNT_EN
      chk("dflt_ovl_cnt", last_cnt, 2);
`endif
      // Non-overlapping
      cfg(8'h12, 5, 1'b0);
      o0 = obs; send(32'b10010010, 8); drain();
      chk("nonovl_matches", obs - o0, 1);
`ifdef SEQ_DET_CNT_EN
      chk("nonovl_cnt", last_cnt, 3);
`endif
      // Gaps in the valid stream
      cfg(8'h12, 5, 1'b1);
      o0 = obs; send(32'b10, 2); idle(3); send(32'b010, 3); drain();
      chk("gap_matches", obs - o0, 1);

      // Full-length all-ones, length 1, length 0, length beyond MAX_LEN
      cfg(8'hFF, ML, 1'b1);
      o0 = obs; send(32'h3FF, 10); drain();
      chk("len_max_matches", obs - o0, 3);
      cfg(8'h01, 1, 1'b1);
      o0 = obs; send(32'b101, 3); drain();
      chk("len1_matches", obs - o0, 2);
      cfg(8'h12, 0, 1'b1);
      o0 = obs; send(32'b10010010, 8); send($urandom, 32); drain();
      chk("len0_matches", obs - o0, 0);
      cfg(8'h12, ML + 1, 1'b1);
      o0 = obs; send(32'hFFFF_FFFF, 20); drain();
      chk("len_over_matches", obs - o0, 0);

      // Counter saturation and clear-on-hit
      do_reset();
      cfg(8'h01, 1, 1'b1);
      o0 = obs; send(32'h1FF, 9); drain();
      chk("sat_matches", obs - o0, 9);
`ifdef SEQ_DET_CNT_EN
      chk("sat_cnt", last_cnt, CMAX);
`endif
      cyc(1'b0, '0, 0, 1'b0, 1'b1, 1'b1, 1'b1); drain();
`ifdef SEQ_DET_CNT_EN
      chk("clr_hit_cnt", last_cnt, 1);
`endif

      // Reset mid-pattern discards history
      do_reset();
      o0 = obs; send(32'b1001, 4); do_reset(); send(32'b0, 1); drain();
      chk("rst_mid_matches", obs - o0, 0);

      // cfg_we with a valid bit drops the bit and clears fill
      o0 = obs; send(32'b1001, 4);
      cyc(1'b1, 8'h12, 5, 1'b1, 1'b1, 1'b0, 1'b0);
      send(32'b0, 1); drain();
      chk("cfg_drop_matches", obs - o0, 0);
      o0 = obs; send(32'b10010, 5); drain();
      chk("after_cfg_matches", obs - o0, 1);

      // Randomised traffic with occasional reconfiguration and clears
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 29) == 0)
            cfg(ML'($urandom), ($urandom_range(0, 4) == 0) ? $urandom_range(0, 9) : $urandom_range(1, 3),
                1'($urandom));
         else
            cyc(1'b0, '0, 0, 1'b0, $urandom_range(0, 9) < 8, 1'($urandom), $urandom_range(0, 19) == 0);
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
